// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt sequencer for the WISC-15 5-stage pipeline.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_op,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_wrt,
  input  logic [3:0]       ex_rd,
  input  logic             mem_redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic luh, hlt;
  assign luh = ex_mem_to_reg && ex_reg_wrt && (ex_rd != 4'd0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  assign hlt = id_op == 4'hF;
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_cnt_d = stall_cnt_q;
    pc_we = 1'b1;
    ifid_we = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_flush = 1'b0;
    halted = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exmem_flush = 1'b1;
        end else if (luh) begin
          pc_we = 1'b0;
          ifid_we = 1'b0;
          idex_flush = 1'b1;
          stall_cnt_d = &stall_cnt_q ? stall_cnt_q : stall_cnt_q + 1'b1;
        end else if (hlt) begin
          pc_we = 1'b0;
          ifid_flush = 1'b1;
          drain_d = DW'(DRAIN_CYCLES);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_redirect) begin
          // an older control transfer put HLT on the wrong path
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exmem_flush = 1'b1;
          drain_d = '0;
          state_d = RUN;
        end else begin
          pc_we = 1'b0;
          ifid_flush = 1'b1;
          drain_d = drain_q - 1'b1;
          state_d = drain_q == DW'(1) ? HALTED : DRAIN;
        end
      end
      default: begin
        pc_we = 1'b0;
        ifid_we = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, redirect, halt drain/abort, reset and saturation.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_op, id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_reg_wrt, mem_redirect;
  logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, halted;
  logic [3:0] stall_cnt;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [5:0] O_RUN = 6'b110000, O_LUH = 6'b000100, O_DRN = 6'b011000,
                         O_RED = 6'b111110, O_HLT = 6'b001101;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_wrt(ex_reg_wrt), .ex_rd(ex_rd), .mem_redirect(mem_redirect),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .stall_cnt(stall_cnt)
  );
  task automatic drive(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic mtr, input logic rw,
                       input logic [3:0] rd, input logic red);
    @(negedge clk);
    rst = 1'b0;
    id_op = op; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_to_reg = mtr; ex_reg_wrt = rw; ex_rd = rd; mem_redirect = red;
    #1;
  endtask
  task automatic idle();
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask
  task automatic chk(input string tag, input logic [5:0] exp, input logic [3:0] exp_cnt);
    logic [5:0] got;
    got = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, halted};
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl got %b expected %b", tag, got, exp);
    end
    n_chk++;
    assert (stall_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s stall_cnt got %0d expected %0d", tag, stall_cnt, exp_cnt);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_op = 4'h0; id_rs = 4'h0; id_rt = 4'h0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_to_reg = 1'b0; ex_reg_wrt = 1'b0; ex_rd = 4'h0; mem_redirect = 1'b0;
  endtask
  initial begin
    do_reset();
    do_reset();
    idle();
    chk("reset", O_RUN, 4'd0);
    drive(4'h8, 4'd3, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    chk("luh_rs", O_LUH, 4'd0);
    drive(4'h8, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("luh_one_bubble", O_RUN, 4'd1);
    drive(4'h8, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    chk("luh_r0", O_RUN, 4'd1);
    drive(4'h8, 4'd2, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
    chk("luh_rt", O_LUH, 4'd1);
    drive(4'h8, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    chk("rt_unused", O_RUN, 4'd2);
    drive(4'h8, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
    chk("no_wrt", O_RUN, 4'd2);
    drive(4'hF, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    chk("redirect_wins", O_RED, 4'd2);
    idle();
    chk("redirect_no_drain", O_RUN, 4'd2);
    drive(4'hF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("hlt_decode", O_DRN, 4'd2);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("drain_%0d", i), O_DRN, 4'd2);
    end
    for (int i = 0; i < 22; i++) begin
      drive(4'h8, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'(i % 2));
      chk($sformatf("halted_%0d", i), O_HLT, 4'd2);
    end
    do_reset();
    idle();
    chk("reset_halted", O_RUN, 4'd0);
    drive(4'hF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("abort_decode", O_DRN, 4'd0);
    idle();
    chk("abort_drain1", O_DRN, 4'd0);
    drive(4'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("abort_redirect", O_RED, 4'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk($sformatf("abort_run_%0d", i), O_RUN, 4'd0);
    end
    drive(4'h8, 4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    chk("pre_rst_luh", O_LUH, 4'd0);
    drive(4'hF, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_drain_decode", O_DRN, 4'd1);
    idle();
    chk("rst_drain1", O_DRN, 4'd1);
    do_reset();
    idle();
    chk("reset_drain", O_RUN, 4'd0);
    for (int i = 0; i < 20; i++) begin
      drive(4'h8, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
      chk($sformatf("sat_%0d", i), O_LUH, 4'(i > 15 ? 15 : i));
    end
    idle();
    chk("sat_final", O_RUN, 4'd15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the WISC-15 5-stage pipeline (IF, ID, EX, MEM, WB).
- Consumes the decoded opcode in ID plus register-address and writeback info from later stages.
- Drives PC and IF/ID write enables and the per-stage bubble/flush controls.
- Owns the halt drain: after HLT decodes, it counts the older instructions out of the pipe, then holds the core halted.

Parameters:
- DRAIN_CYCLES, 4, cycles from HLT leaving ID until all older instructions have passed WB.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_op  in  4  opcode of the instruction in ID (1111 = HLT).
- id_rs  in  4  first source register in ID.
- id_rt  in  4  second source register in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_mem_to_reg  in  1  instruction in EX is a load (LW).
- ex_reg_wrt  in  1  instruction in EX writes a register.
- ex_rd  in  4  destination register of the instruction in EX.
- mem_redirect  in  1  taken branch, CALL or RET resolved in MEM; the PC is being redirected this cycle.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID pipeline register write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  load a NOP into ID/EX.
- exmem_flush  out  1  load a NOP into EX/MEM.
- halted  out  1  core is fully halted.
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.

Behaviour:
- State machine states: RUN, DRAIN, HALTED. The state register and counters are sequential; all outputs are combinational from the current state and inputs.
- Reset (rst=1 at a clk edge):
  - State is RUN; drain counter and stall_cnt are 0.
  - Outputs after reset with inputs idle: pc_we=1, ifid_we=1, all flushes 0, halted=0.
  - Reset in any state, including mid-DRAIN or HALTED, returns to RUN on that edge.
- Load-use hazard (luh) is asserted when all of the following hold:
  - ex_mem_to_reg=1 and ex_reg_wrt=1;
  - ex_rd != 0 (R0 is hardwired zero and never hazards);
  - (id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd).
- RUN priority, highest first:
  1. mem_redirect=1:
     - ifid_flush=1, idex_flush=1, exmem_flush=1, pc_we=1, ifid_we=1.
     - luh and a HLT in ID are ignored, since both are on the wrong path.
  2. luh=1:
     - pc_we=0, ifid_we=0, idex_flush=1.
     - Exactly one bubble is inserted; next cycle the load is in MEM and luh deasserts. The forwarding unit covers MEM-to-EX.
     - stall_cnt increments by 1, saturating at all-ones.
  3. id_op==1111:
     - pc_we=0 and ifid_flush=1; HLT advances to EX.
     - Counter loads DRAIN_CYCLES; next state is DRAIN.
  4. Otherwise: pc_we=1, ifid_we=1, all flushes 0.
- DRAIN:
  - pc_we=0 and ifid_flush=1 every cycle. idex_flush=0 so HLT and older instructions keep advancing.
  - Counter decrements by 1 per cycle. On the cycle the counter equals 1, next state is HALTED.
  - If mem_redirect=1 during DRAIN (an older control transfer makes HLT wrong-path):
    - Abort: apply the RUN redirect outputs (all three flushes, pc_we=1, ifid_we=1).
    - Next state is RUN and the counter clears.
- HALTED:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, exmem_flush=0, halted=1.
  - mem_redirect and luh are ignored. Only rst exits this state.
- stall_cnt changes only on luh stalls taken in RUN; it never wraps.

Test Plan:
- Load-use: LW R3 in EX (ex_mem_to_reg=1, ex_reg_wrt=1, ex_rd=3) with ID reading rs=3 -> exactly one cycle of pc_we=0, ifid_we=0, idex_flush=1; stall_cnt goes 0->1. Same case with ex_rd=0 -> no stall.
- Redirect beats stall: mem_redirect=1 together with luh and id_op=1111 in the same cycle -> ifid_flush=idex_flush=exmem_flush=1, pc_we=1, no DRAIN entry, stall_cnt unchanged.
- Halt drain: id_op=1111 with no hazards, DRAIN_CYCLES=4 -> 4 DRAIN cycles with pc_we=0, then halted=1 on the 5th cycle after decode and held for 20+ cycles despite mem_redirect pulses.
- Halt abort: HLT enters DRAIN, then mem_redirect=1 on the second DRAIN cycle -> all flushes=1, state returns to RUN, halted never asserts, next cycle pc_we=1.
- Reset mid-operation: rst=1 during DRAIN and again during HALTED -> next cycle pc_we=1, ifid_we=1, halted=0, stall_cnt=0.
- Saturation: CNT_W=4, apply 20 back-to-back load-use stalls -> stall_cnt stops at 15.
